// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder: widths, format codes, immediate
// field widths, opcode definitions and the immediate range helper.
package instr_encoder_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } fmt_t;

    localparam int IMM_W_I  = 12;
    localparam int IMM_W_D  = 9;
    localparam int IMM_W_CB = 19;
    localparam int IMM_W_B  = 26;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_LSL  = 11'h69B;
    localparam logic [10:0] OP_ADDI = 11'h488;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_B    = 11'h0A0;
    localparam logic [10:0] OP_CBZ  = 11'h5A0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // True when imm equals the sign-extension of its low 'width' bits.
    function automatic logic imm_fits(input logic [WORD-1:0] imm, input int width);
        logic fits;
        fits = 1'b1;
        for (int b = 0; b < WORD; b++) begin
            if (b >= width - 1 && imm[b] != imm[width-1]) begin
                fits = 1'b0;
            end
        end
        return fits;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: instruction fields -> encoded word plus imm_err.
// Range checking of immediates is enabled by INSTR_ENCODER_RANGE_CHECK_EN.
module instr_field_pack #(
    parameter int WORD      = instr_encoder_pkg::WORD,
    parameter int INSTR_LEN = instr_encoder_pkg::INSTR_LEN
) (
    input  logic [2:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rn,
    input  logic [4:0]           rm,
    input  logic [5:0]           shamt,
    input  logic [WORD-1:0]      imm,
    output logic [INSTR_LEN-1:0] word,
    output logic                 imm_err
);
    import instr_encoder_pkg::*;

    logic [31:0] enc;
    logic        range_bad;

    always_comb begin
        enc       = '0;
        imm_err   = 1'b0;
        range_bad = 1'b0;
        case (fmt)
            FMT_R:  enc = {opcode, rm, shamt, rn, rd};
            FMT_I: begin
                enc       = {opcode[10:1], imm[11:0], rn, rd};
                range_bad = !imm_fits(imm, IMM_W_I);
            end
            FMT_D: begin
                enc       = {opcode, imm[8:0], 2'b00, rn, rd};
                range_bad = !imm_fits(imm, IMM_W_D);
            end
            FMT_CB: begin
                enc       = {opcode[10:3], imm[18:0], rd};
                range_bad = !imm_fits(imm, IMM_W_CB);
            end
            FMT_B: begin
                enc       = {opcode[10:5], imm[25:0]};
                range_bad = !imm_fits(imm, IMM_W_B);
            end
            default: imm_err = 1'b1;
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (range_bad) begin
            imm_err = 1'b1;
        end
`endif
    end

`ifndef INSTR_ENCODER_RANGE_CHECK_EN
    logic range_bad_unused;
    assign range_bad_unused = range_bad;
`endif

    assign word = INSTR_LEN'(enc);

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder job engine: FSM, job counters and a one-deep output register.
// Optional immediate range checking and err_cnt via INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int WORD      = instr_encoder_pkg::WORD,
    parameter int INSTR_LEN = instr_encoder_pkg::INSTR_LEN,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD-1:0]      base_addr,
    input  logic [LEN_W-1:0]     job_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rn,
    input  logic [4:0]           rm,
    input  logic [5:0]           shamt,
    input  logic [WORD-1:0]      imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] instr,
    output logic [WORD-1:0]      addr,
    output logic                 imm_err,
    output logic                 done,
    output logic                 busy
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    ,
    output logic [7:0]           err_cnt
`endif
);
    import instr_encoder_pkg::*;

    state_t               state_reg;
    logic [LEN_W-1:0]     acc_left_reg;
    logic [LEN_W-1:0]     out_left_reg;
    logic                 out_valid_reg;
    logic [INSTR_LEN-1:0] instr_reg;
    logic [WORD-1:0]      addr_reg;
    logic                 imm_err_reg;
    logic                 done_reg;
    logic [INSTR_LEN-1:0] pack_word;
    logic                 pack_err;
    logic                 in_fire;
    logic                 out_fire;

    instr_field_pack #(
        .WORD      (WORD),
        .INSTR_LEN (INSTR_LEN)
    ) u_pack (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .rn      (rn),
        .rm      (rm),
        .shamt   (shamt),
        .imm     (imm),
        .word    (pack_word),
        .imm_err (pack_err)
    );

    // A new word may enter whenever the output slot is empty or draining this cycle.
    assign in_ready  = (state_reg == ST_ACTIVE) && (acc_left_reg != '0) &&
                       (!out_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;
    assign out_valid = out_valid_reg;
    assign instr     = instr_reg;
    assign addr      = addr_reg;
    assign imm_err   = imm_err_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_left_reg  <= '0;
            out_left_reg  <= '0;
            out_valid_reg <= 1'b0;
            instr_reg     <= '0;
            addr_reg      <= '0;
            imm_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg     <= base_addr;
                        acc_left_reg <= job_len;
                        out_left_reg <= job_len;
                        state_reg    <= (job_len == '0) ? ST_DONE : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (in_fire) begin
                        instr_reg     <= pack_word;
                        imm_err_reg   <= pack_err;
                        acc_left_reg  <= acc_left_reg - LEN_W'(1);
                        out_valid_reg <= 1'b1;
                    end else if (out_fire) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (out_fire) begin
                        addr_reg     <= addr_reg + WORD'(4);
                        out_left_reg <= out_left_reg - LEN_W'(1);
                        if (out_left_reg == LEN_W'(1)) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic [7:0] err_cnt_reg;
    assign err_cnt = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            err_cnt_reg <= '0;
        end else if (out_fire && imm_err_reg && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, scoreboard, stall/reset and empty-job sequences.
`timescale 1ns/1ps
module tb_instr_encoder;
    import instr_encoder_pkg::*;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, out_valid, out_ready;
    logic        imm_err, done, busy;
    logic [63:0] base_addr, imm, addr;
    logic [15:0] job_len;
    logic [2:0]  fmt;
    logic [10:0] opcode;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  shamt;
    logic [31:0] instr;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .job_len(job_len),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
        .imm_err(imm_err), .done(done), .busy(busy)
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        , .err_cnt(err_cnt)
`endif
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [10:0] opcode;
        logic [4:0]  rd, rn, rm;
        logic [5:0]  shamt;
        logic [63:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    vec_t tbl [13];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [2:0] f, input logic [10:0] op, input logic [4:0] d,
                                input logic [4:0] n, input logic [4:0] m, input logic [5:0] sh,
                                input logic [63:0] im, input logic [31:0] ei, input logic ee);
        vec_t v;
        v.fmt = f; v.opcode = op; v.rd = d; v.rn = n; v.rm = m; v.shamt = sh;
        v.imm = im; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    task automatic apply(input vec_t v);
        fmt = v.fmt; opcode = v.opcode; rd = v.rd; rn = v.rn; rm = v.rm;
        shamt = v.shamt; imm = v.imm;
    endtask

    // Runs one job over tbl[first +: n]; expected words are queued on input handshake
    // and compared on output handshake.
    task automatic run_job(input logic [63:0] base, input int first, input int n,
                           input int rdy_pct, input int vld_pct, input logic noise, input logic tp);
        int vi, out_cnt, cyc, n_err;
        int out_cyc [$];
        exp_t e;
        logic acc;
        logic [3:0] dseq;
        vi = first; out_cnt = 0; cyc = 0; n_err = 0;
        sb.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; job_len = 16'(n); in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = noise; base_addr = ~base; job_len = 16'd7;
        while (out_cnt < n && cyc < 400) begin
            if (vi < first + n) apply(tbl[vi]);
            in_valid  = (vi < first + n) && ($urandom_range(99) < vld_pct);
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (cyc == 0) check("busy_active", 64'(busy), 64'd1);
            acc = in_valid && in_ready;
            if (acc) sb.push_back('{tbl[vi].exp_instr, tbl[vi].exp_err});
            if (vi >= first + n) check("in_ready_exhausted", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("sb_underflow");
                end else begin
                    e = sb.pop_front();
                    check("instr", 64'(instr), 64'(e.instr));
                    check("imm_err", 64'(imm_err), 64'(e.err));
                    check("addr", addr, base + 64'(out_cnt) * 64'd4);
                    if (e.err) n_err++;
                end
                out_cyc.push_back(cyc);
                out_cnt++;
            end
            @(posedge clk); #1;
            if (acc) vi++;
            cyc++;
        end
        if (out_cnt < n) fail_now("job_timeout");
        start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dseq[k] = done;
        end
        check("done_pulse", 64'(dseq), 64'b0010);
        check("busy_after_done", 64'(busy), 64'd0);
        if (tp) begin
            for (int k = 1; k < out_cyc.size(); k++)
                check("throughput", 64'(out_cyc[k] - out_cyc[k-1]), 64'd1);
        end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        check("err_cnt", 64'(err_cnt), 64'(n_err));
`endif
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [2:0] d3, b3;
        logic       ir;

        tbl[0]  = mk(FMT_I,  OP_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 64'd5,            32'h91001441, 1'b0);
        tbl[1]  = mk(FMT_D,  OP_LDUR, 5'd1, 5'd2, 5'd0, 6'd0, 64'd8,            32'hF8408041, 1'b0);
        tbl[2]  = mk(FMT_B,  OP_B,    5'd0, 5'd0, 5'd0, 6'd0, -64'sd1,          32'h17FFFFFF, 1'b0);
        tbl[3]  = mk(FMT_CB, OP_CBZ,  5'd3, 5'd0, 5'd0, 6'd0, -64'sd2,          32'hB4FFFFC3, 1'b0);
        tbl[4]  = mk(FMT_R,  OP_ADD,  5'd1, 5'd2, 5'd3, 6'd0, 64'h123456789ABC, 32'h8B030041, 1'b0);
        tbl[5]  = mk(FMT_R,  OP_LSL,  5'd1, 5'd2, 5'd0, 6'd5, 64'd0,            32'hD3601441, 1'b0);
        tbl[6]  = mk(3'd7,   OP_ADDI, 5'd9, 5'd9, 5'd9, 6'd9, 64'd9,            32'h00000000, 1'b1);
        tbl[7]  = mk(FMT_I,  OP_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, -64'sd1,          32'h913FFC41, 1'b0);
        tbl[8]  = mk(FMT_D,  OP_LDUR, 5'd1, 5'd2, 5'd0, 6'd0, -64'sd256,        32'hF8500041, 1'b0);
        tbl[9]  = mk(FMT_I,  OP_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 64'd4096,         32'h91000041, RC);
        tbl[10] = mk(FMT_D,  OP_LDUR, 5'd1, 5'd2, 5'd0, 6'd0, 64'd256,          32'hF8500041, RC);
        tbl[11] = mk(FMT_B,  OP_B,    5'd0, 5'd0, 5'd0, 6'd0, 64'd33554432,     32'h16000000, RC);
        tbl[12] = mk(FMT_CB, OP_CBZ,  5'd3, 5'd0, 5'd0, 6'd0, -64'sd262144,     32'hB4800003, 1'b0);

        reset = 1'b1; start = 1'b0; base_addr = '0; job_len = '0;
        in_valid = 1'b0; out_ready = 1'b0; apply(tbl[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_addr", addr, 64'd0);
        check("rst_imm_err", 64'(imm_err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        run_job(64'h100, 0, 1, 100, 100, 1'b0, 1'b0);
        run_job(64'h0, 1, 3, 100, 100, 1'b0, 1'b1);
        run_job(64'h40, 9, 1, 100, 100, 1'b0, 1'b0);
        run_job(64'h1000, 0, 13, 60, 70, 1'b1, 1'b0);
        run_job(64'hFFFF_FFFF_FFFF_FFF0, 0, 13, 30, 90, 1'b1, 1'b0);

        // Stall the output for five cycles, then reset in the middle of the stall.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 64'h200; job_len = 16'd2; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; apply(tbl[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        apply(tbl[1]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_instr", 64'(instr), 64'(tbl[0].exp_instr));
            check("stall_addr", addr, 64'h200);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_instr", 64'(instr), 64'd0);
        check("midrst_addr", addr, 64'd0);
        reset = 1'b0; in_valid = 1'b0;

        run_job(64'h300, 4, 2, 100, 100, 1'b0, 1'b1);

        // Empty job: no input acceptance, done two cycles after start.
        @(posedge clk); #1;
        start = 1'b1; job_len = 16'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            d3[k] = done;
            b3[k] = busy;
            ir = ir | in_ready;
        end
        in_valid = 1'b0;
        check("len0_done", 64'(d3), 64'b010);
        check("len0_busy", 64'(b3), 64'b001);
        check("len0_in_ready", 64'(ir), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
